// File: rtl/bus_hub_n.sv
// bus_hub_n: single-host to N-device bus hub.
// One transaction at a time. The request and the selected device are latched at accept.
// The selected device sees a steady strobe until it answers. The host then gets a one-cycle
// host_ready pulse together with registered data and error.
// Optional feature macro: BUS_HUB_TIMEOUT_EN aborts an ACTIVE transaction after
// TIMEOUT_CYCLES cycles and reports it as an error.
module bus_hub_n #(
  parameter int N_DEVICES      = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int MASK_W        = DATA_W / 8,
  localparam int SEL_W         = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             host_address,
  input  logic [DATA_W-1:0]             host_data_write,
  input  logic [MASK_W-1:0]             host_write_mask,
  input  logic                          host_ren,
  input  logic                          host_wen,
  output logic [DATA_W-1:0]             host_data_read,
  output logic                          host_ready,
  output logic                          host_error,
  output logic [N_DEVICES*ADDR_W-1:0]   device_address,
  output logic [N_DEVICES*DATA_W-1:0]   device_data_write,
  output logic [N_DEVICES*MASK_W-1:0]   device_write_mask,
  output logic [N_DEVICES-1:0]          device_ren,
  output logic [N_DEVICES-1:0]          device_wen,
  input  logic [N_DEVICES-1:0]          device_ready,
  input  logic [N_DEVICES*DATA_W-1:0]   device_data_read,
  input  logic [N_DEVICES-1:0]          device_active
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic              wr;
  } req_t;

  logic [1:0]        state_q, state_d;
  req_t              req_q, req_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  sel_enc;
  logic [DATA_W-1:0] rd_sel;
  logic              rdy_sel;

`ifdef BUS_HUB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Keeps the parameter referenced in builds without the timeout counter.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES >= 1);
`endif

  // Priority encoder: highest set device_active bit wins.
  always_comb begin
    sel_enc = '0;
    for (int i = 0; i < N_DEVICES; i++)
      if (device_active[i]) sel_enc = SEL_W'(i);
  end

  // Return-path mux for the latched device (loop form avoids out-of-range indexing).
  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    for (int i = 0; i < N_DEVICES; i++)
      if (sel_q == SEL_W'(i)) begin
        rd_sel  = device_data_read[i*DATA_W +: DATA_W];
        rdy_sel = device_ready[i];
      end
  end

  // Next-state and latch updates for the transaction FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_HUB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef BUS_HUB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (host_ren || host_wen) begin
          req_d.addr = host_address;
          req_d.data = host_data_write;
          req_d.mask = host_write_mask;
          req_d.wr   = host_wen;
          if (|device_active) begin
            sel_d   = sel_enc;
            state_d = ACTIVE;
          end else begin
            // Unmapped address: complete right away with an error.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACTIVE: begin
        if (rdy_sel) begin
          rdata_d = req_q.wr ? '0 : rd_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_HUB_TIMEOUT_EN
        // A ready on the final allowed cycle still counts as a normal completion.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_HUB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_HUB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign host_data_read    = rdata_q;
  assign host_error        = err_q;
  assign host_ready        = (state_q == RESP);
  assign device_address    = {N_DEVICES{req_q.addr}};
  assign device_data_write = {N_DEVICES{req_q.data}};
  assign device_write_mask = {N_DEVICES{req_q.mask}};

  // Per-device strobes: only the latched device, only while ACTIVE.
  for (genvar g = 0; g < N_DEVICES; g++) begin : g_strb
    assign device_ren[g] = (state_q == ACTIVE) && (sel_q == SEL_W'(g)) && !req_q.wr;
    assign device_wen[g] = (state_q == ACTIVE) && (sel_q == SEL_W'(g)) &&  req_q.wr;
  end

endmodule

// File: tb/tb_bus_hub_n.sv
// Self-checking bench for bus_hub_n (N_DEVICES=4, 32-bit, TIMEOUT_CYCLES=8).
// Completions are checked against a scoreboard queue filled as requests are issued.
module tb_bus_hub_n;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     host_address;
  logic [DW-1:0]     host_data_write;
  logic [MW-1:0]     host_write_mask;
  logic              host_ren, host_wen;
  logic [DW-1:0]     host_data_read;
  logic              host_ready, host_error;
  logic [N*AW-1:0]   device_address;
  logic [N*DW-1:0]   device_data_write;
  logic [N*MW-1:0]   device_write_mask;
  logic [N-1:0]      device_ren, device_wen;
  logic [N-1:0]      device_ready;
  logic [N*DW-1:0]   device_data_read;
  logic [N-1:0]      device_active;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  bus_hub_n #(.N_DEVICES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_address(host_address), .host_data_write(host_data_write),
    .host_write_mask(host_write_mask), .host_ren(host_ren), .host_wen(host_wen),
    .host_data_read(host_data_read), .host_ready(host_ready), .host_error(host_error),
    .device_address(device_address), .device_data_write(device_data_write),
    .device_write_mask(device_write_mask), .device_ren(device_ren), .device_wen(device_wen),
    .device_ready(device_ready), .device_data_read(device_data_read),
    .device_active(device_active)
  );

  always #5 clk = ~clk;

  // Completion monitor: every host_ready must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && host_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_ready: host_ready=1 with no outstanding request (data=%h err=%b)",
                 host_data_read, host_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (host_data_read !== e.data || host_error !== e.err) begin
          tests_failed++;
          $display("FAIL completion: got data=%h err=%b, expected data=%h err=%b",
                   host_data_read, host_error, e.data, e.err);
        end
      end
    end
  end

  // Drive a request so it is accepted on the next rising edge, then drop it.
  task automatic issue(input logic ren, input logic wen, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m, input logic [N-1:0] act);
    @(posedge clk); #1;
    host_ren = ren; host_wen = wen; host_address = a;
    host_data_write = d; host_write_mask = m; device_active = act;
    @(posedge clk); #1;
    host_ren = 1'b0; host_wen = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    host_ren = 0; host_wen = 0; host_address = '0; host_data_write = '0;
    host_write_mask = '0; device_ready = '0; device_data_read = '0; device_active = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b0 || host_error !== 1'b0 || host_data_read !== '0) begin
      tests_failed++;
      $display("FAIL reset_host: ready=%b err=%b data=%h, expected 0/0/0", host_ready, host_error, host_data_read);
    end
    tests_run++;
    if (device_ren !== '0 || device_wen !== '0) begin
      tests_failed++;
      $display("FAIL reset_strobes: ren=%b wen=%b, expected 0/0", device_ren, device_wen);
    end
    tests_run++;
    if (device_address !== '0 || device_data_write !== '0 || device_write_mask !== '0) begin
      tests_failed++;
      $display("FAIL reset_latches: addr=%h data=%h mask=%h, expected 0", device_address, device_data_write, device_write_mask);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_read;
    device_data_read[2*DW +: DW] = 32'hDEADBEEF;
    device_data_read[1*DW +: DW] = 32'h11111111;
    sb.push_back('{32'hDEADBEEF, 1'b0});
    issue(1, 0, 32'h0000_2000, 32'h0, 4'h0, 4'b0100);
    // cycle k+1: strobe up, not yet ready
    device_ready = 4'b0100;
    @(negedge clk);
    tests_run++;
    if (device_ren !== 4'b0100 || device_wen !== 4'b0000 || host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_strobe: ren=%b wen=%b rdy=%b, expected 0100/0000/0", device_ren, device_wen, host_ready);
    end
    @(posedge clk); #1; device_ready = '0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1 || device_ren !== 4'b0000) begin
      tests_failed++;
      $display("FAIL read_latency: host_ready=%b ren=%b, expected 1/0000", host_ready, device_ren);
    end
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b0 || host_data_read !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL read_pulse_hold: host_ready=%b data=%h, expected 0/deadbeef", host_ready, host_data_read);
    end
  endtask

  task automatic test_unmapped;
    sb.push_back('{32'h0, 1'b1});
    issue(1, 0, 32'hFFFF_0000, 32'h0, 4'h0, 4'b0000);
    @(negedge clk); // cycle k+1
    tests_run++;
    if (host_ready !== 1'b1 || device_ren !== '0 || device_wen !== '0) begin
      tests_failed++;
      $display("FAIL unmapped: host_ready=%b ren=%b wen=%b, expected 1/0000/0000", host_ready, device_ren, device_wen);
    end
    @(negedge clk);
  endtask

  task automatic test_write;
    device_data_read[0 +: DW] = 32'hCAFEF00D; // must not leak on a write
    sb.push_back('{32'h0, 1'b0});
    issue(1, 1, 32'hA5A5_0010, 32'h1234_5678, 4'b0011, 4'b0001);
    // scramble host inputs; the latched copy must not move
    host_address = 32'h0BAD_0BAD; host_data_write = 32'hFFFF_FFFF; host_write_mask = 4'hF;
    device_active = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (device_wen !== 4'b0001 || device_ren !== 4'b0000 ||
          device_address[0 +: AW] !== 32'hA5A5_0010 || device_address[3*AW +: AW] !== 32'hA5A5_0010 ||
          device_data_write[2*DW +: DW] !== 32'h1234_5678 || device_write_mask[0 +: MW] !== 4'b0011) begin
        tests_failed++;
        $display("FAIL write_hold c%0d: wen=%b ren=%b addr0=%h data2=%h mask0=%b",
                 c, device_wen, device_ren, device_address[0 +: AW], device_data_write[2*DW +: DW], device_write_mask[0 +: MW]);
      end
      if (c == 3) device_ready = 4'b0001;
    end
    @(posedge clk); #1; device_ready = '0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1 || device_wen !== 4'b0000) begin
      tests_failed++;
      $display("FAIL write_done: host_ready=%b wen=%b, expected 1/0000", host_ready, device_wen);
    end
    @(negedge clk);
  endtask

  task automatic test_multihot;
    device_data_read[3*DW +: DW] = 32'h3333_3333;
    sb.push_back('{32'h3333_3333, 1'b0});
    issue(1, 0, 32'h0000_3000, 32'h0, 4'h0, 4'b1010);
    device_active = 4'b0001;
    device_ready  = 4'b0011; // unselected readies must be ignored
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (device_ren !== 4'b1000 || host_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL multihot c%0d: ren=%b rdy=%b, expected 1000/0", c, device_ren, host_ready);
      end
    end
    device_ready = 4'b1000;
    @(posedge clk); #1; device_ready = '0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL multihot_done: host_ready=%b expected 1", host_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cnt;
    device_data_read[0 +: DW] = 32'h5555_AAAA;
`ifdef BUS_HUB_TIMEOUT_EN
    sb.push_back('{32'h0, 1'b1});
    issue(1, 0, 32'h40, 32'h0, 4'h0, 4'b0001);
    cnt = 1; // strobe already high in the cycle after accept
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (device_ren[0]) cnt++;
      else break;
    end
    tests_run++;
    if (cnt !== 9 || host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout: strobe cycles=%0d host_ready=%b, expected 8/1", cnt - 1, host_ready);
    end
`else
    issue(1, 0, 32'h40, 32'h0, 4'h0, 4'b0001);
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (device_ren[0]) cnt++;
    end
    tests_run++;
    if (cnt !== 1000 || device_ren !== 4'b0001) begin
      tests_failed++;
      $display("FAIL no_timeout: strobe cycles=%0d ren=%b, expected 1000/0001", cnt, device_ren);
    end
    sb.push_back('{32'h5555_AAAA, 1'b0});
    device_ready = 4'b0001;
    @(posedge clk); #1; device_ready = '0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_timeout_done: host_ready=%b expected 1", host_ready);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(1, 0, 32'h0000_2004, 32'h0, 4'h0, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (device_ren !== '0 || device_wen !== '0 || host_ready !== 1'b0 ||
        host_data_read !== '0 || device_address !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: ren=%b wen=%b rdy=%b data=%h addr=%h, expected all 0",
               device_ren, device_wen, host_ready, host_data_read, device_address);
    end
    device_ready = 4'b0100;
    @(posedge clk); #1; device_ready = '0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // follow-up request served normally
    device_data_read[1*DW +: DW] = 32'h0F0F_1234;
    sb.push_back('{32'h0F0F_1234, 1'b0});
    issue(1, 0, 32'h0000_1000, 32'h0, 4'h0, 4'b0010);
    device_ready = 4'b0010;
    @(posedge clk); #1; device_ready = '0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_recover: host_ready=%b expected 1", host_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_read;
    test_unmapped;
    test_write;
    test_multihot;
    test_timeout;
    test_reset_mid;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
